hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised pipeline-control block for the 5-stage MIPS core: forwarding selects, load-use interlock, control-transfer flush and a multi-cycle mul/div interlock in one unit. Sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipe registers and drives their enable and flush inputs, plus the EX-stage operand forwarding muxes. Successor to the bare forwarding unit: configurable register-address width, branch-resolve stage and mul/div latency. Register 0 is never forwarded.

## Interface
- REG_AW, 5, register-address width
- BRANCH_STAGE, 3, stage resolving branch/jump/jr: 1=ID, 2=EX, 3=MEM
- MULDIV_LAT, 32, mul/div occupancy in cycles, ≥2
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low
- id_rs, id_rt  in  REG_AW each  source registers of instruction in ID
- id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs/rt
- id_muldiv  in  1  ID holds mult/div (starts unit)
- id_hilo  in  1  ID holds mfhi/mflo
- ex_rs, ex_rt  in  REG_AW each  sources of instruction in EX
- ex_memread  in  1  EX instruction is a load
- ex_wreg  in  REG_AW  EX destination
- mem_regwrite, wb_regwrite  in  1 each
- mem_wreg, wb_wreg  in  REG_AW each
- redirect  in  1  control transfer taken at BRANCH_STAGE
- fwd_a, fwd_b  out  2 each  00 regfile/imm, 10 from MEM, 11 from WB
- pc_en, if_id_en  out  1 each  PC / IF-ID pipe enable
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  bubble insert
- muldiv_busy  out  1  mul/div counter non-zero
- stall_cnt  out  16  saturating count of stalled cycles

## Operation
- Forwarding (per operand, A=ex_rs, B=ex_rt): MEM match when mem_regwrite && mem_wreg==src && src!=0 → 10; else WB match likewise → 11; else 00. MEM beats WB.
- Load-use: ex_memread && ex_wreg!=0 && ((id_use_rs && id_rs==ex_wreg) || (id_use_rt && id_rt==ex_wreg)) → pc_en=0, if_id_en=0, id_ex_flush=1 for that cycle.
- Mul/div: counter cnt. id_muldiv while cnt==0 and no stall/redirect → cnt loads MULDIV_LAT-1 next edge; decrements each cycle to 0. While cnt!=0, id_muldiv or id_hilo → same stall as load-use.
- Redirect: one-cycle flush of younger stages: if_id_flush=1 always; id_ex_flush=1 if BRANCH_STAGE≥2; ex_mem_flush=1 if BRANCH_STAGE=3. pc_en=1, if_id_en=1.
- Priority: reset > redirect > stall > run. Redirect cancels a concurrent stall; a mul/div in ID flushed by redirect does not start.
- stall_cnt increments each cycle pc_en=0 with reset high; saturates at 0xFFFF.
- FSM: RUN (no hazard), STALL (load-use or mul/div interlock), FLUSH (redirect). State registered for stall_cnt and debug; outputs decoded from current inputs plus cnt.

## Timing
- fwd_a/fwd_b, pc_en, if_id_en, flushes: combinational from inputs and cnt, same cycle.
- Load-use costs exactly 1 stall cycle; redirect costs BRANCH_STAGE bubbles.
- mul/div issued at edge t: muldiv_busy high cycles t+1..t+MULDIV_LAT-1; dependent mfhi stalls until cnt==0.
- While reset low: fwd 00, pc_en=0, if_id_en=0, all flushes=1, cnt=0, stall_cnt=0, state RUN, muldiv_busy=0. Reset mid mul/div clears cnt immediately.
- After reset release with quiet inputs: pc_en=1, if_id_en=1, flushes 0.

## Configuration
- HAZARD_MULDIV_EN defined: mul/div counter and interlock present.
- Undefined: cnt removed, muldiv_busy tied 0, id_muldiv/id_hilo ignored; MULDIV_LAT unused.

## Structure
- Shared package hazard_pkg: fwd encoding constants (FWD_RF, FWD_MEM, FWD_WB), FSM state enum, stall_cnt width.
- One sub-module fwd_sel instantiated twice (operand A, B).

## Test plan
- mem_regwrite=1, mem_wreg=8, wb_regwrite=1, wb_wreg=8, ex_rs=8 → fwd_a=10; drop mem_regwrite → 11; ex_rs=0 with wregs=0 → 00.
- ex_memread=1, ex_wreg=9, id_rt=9, id_use_rt=1 → one cycle pc_en=0, if_id_en=0, id_ex_flush=1, stall_cnt 0→1.
- BRANCH_STAGE=3, redirect=1 with concurrent load-use → if_id/id_ex/ex_mem flushes=1, pc_en=1, stall_cnt unchanged.
- HAZARD_MULDIV_EN, MULDIV_LAT=4: id_muldiv at t, id_hilo from t+1 → busy t+1..t+3, stall 3 cycles, released at t+4.
- Reset low during mul/div busy → muldiv_busy=0 next edge, all flushes 1, pc_en 0; release → RUN.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding codes, FSM states, counter widths.
package hazard_pkg;

    localparam int unsigned STALL_CNT_W = 16;
    localparam int unsigned FWD_W       = 2;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// EX-stage operand forwarding select for one source operand; MEM result beats WB, r0 never forwarded.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_src,
    input  logic              i_mem_regwrite,
    input  logic [REG_AW-1:0] i_mem_wreg,
    input  logic              i_wb_regwrite,
    input  logic [REG_AW-1:0] i_wb_wreg,
    output logic [FWD_W-1:0]  o_sel_c
);

    logic w_src_nz;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_src_nz  = (i_src != '0);
    assign w_mem_hit = i_mem_regwrite && (i_mem_wreg == i_src) && w_src_nz;
    assign w_wb_hit  = i_wb_regwrite && (i_wb_wreg == i_src) && w_src_nz;

    always_comb begin
        o_sel_c = FWD_RF;
        if (w_mem_hit) begin
            o_sel_c = FWD_MEM;
        end else if (w_wb_hit) begin
            o_sel_c = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline control: forwarding, load-use and mul/div interlocks, redirect flush.
// Define HAZARD_MULDIV_EN to build the mul/div occupancy counter and its interlock.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned BRANCH_STAGE = 3,
    parameter int unsigned MULDIV_LAT   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_AW-1:0]      id_rs,
    input  logic [REG_AW-1:0]      id_rt,
    input  logic                   id_use_rs,
    input  logic                   id_use_rt,
    input  logic                   id_muldiv,
    input  logic                   id_hilo,
    input  logic [REG_AW-1:0]      ex_rs,
    input  logic [REG_AW-1:0]      ex_rt,
    input  logic                   ex_memread,
    input  logic [REG_AW-1:0]      ex_wreg,
    input  logic                   mem_regwrite,
    input  logic                   wb_regwrite,
    input  logic [REG_AW-1:0]      mem_wreg,
    input  logic [REG_AW-1:0]      wb_wreg,
    input  logic                   redirect,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   ex_mem_flush,
    output logic                   muldiv_busy,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic [1:0]             fsm_state
);

    logic [FWD_W-1:0]       w_fwd_a;
    logic [FWD_W-1:0]       w_fwd_b;
    logic                   w_load_use;
    logic                   w_md_stall;
    logic                   w_md_busy;
    logic                   w_stall;
    hz_state_e              r_state;
    hz_state_e              w_state_nxt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .i_src          (ex_rs),
        .i_mem_regwrite (mem_regwrite),
        .i_mem_wreg     (mem_wreg),
        .i_wb_regwrite  (wb_regwrite),
        .i_wb_wreg      (wb_wreg),
        .o_sel_c        (w_fwd_a)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .i_src          (ex_rt),
        .i_mem_regwrite (mem_regwrite),
        .i_mem_wreg     (mem_wreg),
        .i_wb_regwrite  (wb_regwrite),
        .i_wb_wreg      (wb_wreg),
        .o_sel_c        (w_fwd_b)
    );

    assign w_load_use = ex_memread && (ex_wreg != '0) &&
                        ((id_use_rs && (id_rs == ex_wreg)) ||
                         (id_use_rt && (id_rt == ex_wreg)));

`ifdef HAZARD_MULDIV_EN
    localparam int unsigned CNT_W = $clog2(MULDIV_LAT);

    logic [CNT_W-1:0] r_cnt;
    logic             w_md_idle;

    assign w_md_idle  = (r_cnt == '0);
    assign w_md_busy  = !w_md_idle;
    assign w_md_stall = w_md_busy && (id_muldiv || id_hilo);

    // A mul/div only starts when it actually leaves ID this cycle (not stalled, not squashed).
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!w_md_idle) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end else if (id_muldiv && !w_load_use && !redirect) begin
            r_cnt <= CNT_W'(MULDIV_LAT - 1);
        end
    end
`else
    logic w_unused_md;

    assign w_md_busy   = 1'b0;
    assign w_md_stall  = 1'b0;
    assign w_unused_md = ^{id_muldiv, id_hilo, 1'(MULDIV_LAT)};
`endif

    assign w_stall = w_load_use || w_md_stall;

    // Priority: reset > redirect > stall > run.
    always_comb begin
        w_state_nxt  = ST_RUN;
        fwd_a        = w_fwd_a;
        fwd_b        = w_fwd_b;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (!reset) begin
            fwd_a        = FWD_RF;
            fwd_b        = FWD_RF;
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (redirect) begin
            w_state_nxt  = ST_FLUSH;
            if_id_flush  = 1'b1;
            id_ex_flush  = (BRANCH_STAGE >= 2);
            ex_mem_flush = (BRANCH_STAGE == 3);
        end else if (w_stall) begin
            w_state_nxt  = ST_STALL;
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (!pc_en && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign muldiv_busy = reset && w_md_busy;
    assign stall_cnt   = r_stall_cnt;
    assign fsm_state   = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, corner sequences, random run against a reference model.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int unsigned AW  = 5;
    localparam int unsigned BS  = 3;
    localparam int unsigned LAT = 4;
`ifdef HAZARD_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
    logic          id_use_rs, id_use_rt, id_muldiv, id_hilo, ex_memread;
    logic          mem_regwrite, wb_regwrite, redirect;
    logic [1:0]    fwd_a, fwd_b, fsm_state;
    logic          pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, muldiv_busy;
    logic [15:0]   stall_cnt;

    hazard_ctrl #(.REG_AW(AW), .BRANCH_STAGE(BS), .MULDIV_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_muldiv(id_muldiv), .id_hilo(id_hilo),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memread(ex_memread), .ex_wreg(ex_wreg),
        .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
        .mem_wreg(mem_wreg), .wb_wreg(wb_wreg), .redirect(redirect),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_en(pc_en), .if_id_en(if_id_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .muldiv_busy(muldiv_busy), .stall_cnt(stall_cnt), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic [AW-1:0] id_rs, id_rt;
        logic          id_use_rs, id_use_rt, id_muldiv, id_hilo;
        logic [AW-1:0] ex_rs, ex_rt;
        logic          ex_memread;
        logic [AW-1:0] ex_wreg;
        logic          mem_regwrite, wb_regwrite;
        logic [AW-1:0] mem_wreg, wb_wreg;
        logic          redirect;
    } vin_t;

    typedef struct {
        vin_t       v;
        logic [1:0] fa, fb;
        logic       pc, ifid, fl_ifid, fl_idex, fl_exmem;
    } vec_t;

    int        checks   = 0;
    int        failures = 0;
    int        m_left   = 0;
    int        m_stall  = 0;
    hz_state_e m_state  = ST_RUN;
    vec_t      tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic vin_t quiet();
        vin_t v;
        v.rst_n = 1'b1; v.id_rs = '0; v.id_rt = '0; v.id_use_rs = 1'b0; v.id_use_rt = 1'b0;
        v.id_muldiv = 1'b0; v.id_hilo = 1'b0; v.ex_rs = '0; v.ex_rt = '0; v.ex_memread = 1'b0;
        v.ex_wreg = '0; v.mem_regwrite = 1'b0; v.wb_regwrite = 1'b0; v.mem_wreg = '0;
        v.wb_wreg = '0; v.redirect = 1'b0;
        return v;
    endfunction

    task automatic drive(input vin_t v);
        reset = v.rst_n; id_rs = v.id_rs; id_rt = v.id_rt; id_use_rs = v.id_use_rs;
        id_use_rt = v.id_use_rt; id_muldiv = v.id_muldiv; id_hilo = v.id_hilo;
        ex_rs = v.ex_rs; ex_rt = v.ex_rt; ex_memread = v.ex_memread; ex_wreg = v.ex_wreg;
        mem_regwrite = v.mem_regwrite; wb_regwrite = v.wb_regwrite;
        mem_wreg = v.mem_wreg; wb_wreg = v.wb_wreg; redirect = v.redirect;
    endtask

    // Youngest producer with a matching destination wins; r0 is never a forwarding source.
    function automatic logic [1:0] m_fwd(input logic [AW-1:0] src, input vin_t v);
        logic [AW-1:0] dst [2];
        logic          wr  [2];
        logic [1:0]    code[2];
        dst[0] = v.mem_wreg; wr[0] = v.mem_regwrite; code[0] = 2'b10;
        dst[1] = v.wb_wreg;  wr[1] = v.wb_regwrite;  code[1] = 2'b11;
        for (int k = 0; k < 2; k++) begin
            if (wr[k] && src != 0 && dst[k] == src) return code[k];
        end
        return 2'b00;
    endfunction

    function automatic bit m_hazard(input vin_t v);
        bit lu, md;
        lu = v.ex_memread && v.ex_wreg != 0 &&
             ((v.id_use_rs && v.id_rs == v.ex_wreg) || (v.id_use_rt && v.id_rt == v.ex_wreg));
        md = MD_EN && m_left > 0 && (v.id_muldiv || v.id_hilo);
        return lu || md;
    endfunction

    task automatic check_comb(input string tag, input vin_t v);
        logic [1:0] fa, fb;
        logic       pc, ifid, f1, f2, f3;
        fa = m_fwd(v.ex_rs, v); fb = m_fwd(v.ex_rt, v);
        pc = 1; ifid = 1; f1 = 0; f2 = 0; f3 = 0;
        if (!v.rst_n) begin
            fa = 0; fb = 0; pc = 0; ifid = 0; f1 = 1; f2 = 1; f3 = 1;
        end else if (v.redirect) begin
            f1 = 1; f2 = (BS >= 2); f3 = (BS == 3);
        end else if (m_hazard(v)) begin
            pc = 0; ifid = 0; f2 = 1;
        end
        chk({tag, ".fwd_a"}, 32'(fwd_a), 32'(fa));
        chk({tag, ".fwd_b"}, 32'(fwd_b), 32'(fb));
        chk({tag, ".pc_en"}, 32'(pc_en), 32'(pc));
        chk({tag, ".if_id_en"}, 32'(if_id_en), 32'(ifid));
        chk({tag, ".if_id_flush"}, 32'(if_id_flush), 32'(f1));
        chk({tag, ".id_ex_flush"}, 32'(id_ex_flush), 32'(f2));
        chk({tag, ".ex_mem_flush"}, 32'(ex_mem_flush), 32'(f3));
        chk({tag, ".busy"}, 32'(muldiv_busy), 32'(v.rst_n && MD_EN && m_left > 0));
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    endtask

    task automatic model_edge(input vin_t v);
        bit hz;
        hz = m_hazard(v);
        if (!v.rst_n) begin
            m_left = 0; m_stall = 0; m_state = ST_RUN;
        end else begin
            if (!v.redirect && hz && m_stall < 65535) m_stall++;
            m_state = v.redirect ? ST_FLUSH : (hz ? ST_STALL : ST_RUN);
            if (m_left > 0) m_left--;
            else if (MD_EN && v.id_muldiv && !hz && !v.redirect) m_left = LAT - 1;
        end
    endtask

    // One cycle: drive, check combinational outputs, clock, check registered state.
    task automatic step(input string tag, input vin_t v);
        drive(v);
        #1;
        check_comb(tag, v);
        @(posedge clk);
        model_edge(v);
        #1;
        chk({tag, ".state"}, 32'(fsm_state), 32'(m_state));
        chk({tag, ".stall_cnt_q"}, 32'(stall_cnt), 32'(m_stall));
        chk({tag, ".busy_q"}, 32'(muldiv_busy), 32'(v.rst_n && MD_EN && m_left > 0));
    endtask

    initial begin
        vin_t v, q, r;
        q = quiet();
        r = quiet(); r.rst_n = 1'b0;
        drive(r);
        @(posedge clk); model_edge(r); #1;
        step("rst", r);
        chk("rst.stall_cnt0", 32'(stall_cnt), 32'd0);
        chk("rst.state0", 32'(fsm_state), 32'(ST_RUN));

        // Vector table: hand-derived expected combinational outputs.
        v = q; v.mem_regwrite = 1; v.mem_wreg = 8; v.wb_regwrite = 1; v.wb_wreg = 8; v.ex_rs = 8;
        tbl[0] = '{v, 2'b10, 2'b00, 1, 1, 0, 0, 0};
        v.mem_regwrite = 0;
        tbl[1] = '{v, 2'b11, 2'b00, 1, 1, 0, 0, 0};
        v = q; v.mem_regwrite = 1; v.wb_regwrite = 1;
        tbl[2] = '{v, 2'b00, 2'b00, 1, 1, 0, 0, 0};
        v = q; v.mem_regwrite = 1; v.mem_wreg = 5; v.wb_regwrite = 1; v.wb_wreg = 6; v.ex_rs = 6; v.ex_rt = 5;
        tbl[3] = '{v, 2'b11, 2'b10, 1, 1, 0, 0, 0};
        v = q; v.ex_memread = 1; v.ex_wreg = 9; v.id_rs = 9; v.id_use_rs = 1;
        tbl[4] = '{v, 2'b00, 2'b00, 0, 0, 0, 1, 0};
        v.id_use_rs = 0;
        tbl[5] = '{v, 2'b00, 2'b00, 1, 1, 0, 0, 0};
        v = q; v.ex_memread = 1; v.id_rt = 0; v.id_use_rt = 1;
        tbl[6] = '{v, 2'b00, 2'b00, 1, 1, 0, 0, 0};
        v = q; v.redirect = 1;
        tbl[7] = '{v, 2'b00, 2'b00, 1, 1, 1, 1, 1};
        v.ex_memread = 1; v.ex_wreg = 9; v.id_rt = 9; v.id_use_rt = 1;
        tbl[8] = '{v, 2'b00, 2'b00, 1, 1, 1, 1, 1};
        v = q; v.rst_n = 0; v.mem_regwrite = 1; v.mem_wreg = 3; v.ex_rs = 3;
        tbl[9] = '{v, 2'b00, 2'b00, 0, 0, 1, 1, 1};
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v);
            #1;
            chk($sformatf("vec%0d.fwd_a", i), 32'(fwd_a), 32'(tbl[i].fa));
            chk($sformatf("vec%0d.fwd_b", i), 32'(fwd_b), 32'(tbl[i].fb));
            chk($sformatf("vec%0d.pc_en", i), 32'(pc_en), 32'(tbl[i].pc));
            chk($sformatf("vec%0d.if_id_en", i), 32'(if_id_en), 32'(tbl[i].ifid));
            chk($sformatf("vec%0d.if_id_flush", i), 32'(if_id_flush), 32'(tbl[i].fl_ifid));
            chk($sformatf("vec%0d.id_ex_flush", i), 32'(id_ex_flush), 32'(tbl[i].fl_idex));
            chk($sformatf("vec%0d.ex_mem_flush", i), 32'(ex_mem_flush), 32'(tbl[i].fl_exmem));
            @(posedge clk); model_edge(tbl[i].v); #1;
        end

        // Load-use: exactly one stall cycle, counter 0 -> 1.
        step("lu_rst", r);
        v = q; v.ex_memread = 1; v.ex_wreg = 9; v.id_rt = 9; v.id_use_rt = 1;
        step("lu", v);
        chk("lu.stall_cnt1", 32'(stall_cnt), 32'd1);
        chk("lu.state_stall", 32'(fsm_state), 32'(ST_STALL));
        step("lu_after", q);
        chk("lu_after.pc_en", 32'(pc_en), 32'd1);

        // Redirect with concurrent load-use: flush wins, stall counter untouched.
        v.redirect = 1;
        step("redir", v);
        chk("redir.stall_cnt", 32'(stall_cnt), 32'd1);
        chk("redir.state", 32'(fsm_state), 32'(ST_FLUSH));

        // Mul/div issue followed by dependent mfhi.
        v = q; v.id_muldiv = 1;
        step("md_issue", v);
        v = q; v.id_hilo = 1;
        for (int k = 0; k < 4; k++) begin
            drive(v);
            #1;
            chk($sformatf("md_hilo%0d.pc_en", k), 32'(pc_en), 32'((MD_EN && k < 3) ? 0 : 1));
            chk($sformatf("md_hilo%0d.busy", k), 32'(muldiv_busy), 32'(MD_EN && k < 3));
            check_comb($sformatf("md_hilo%0d", k), v);
            @(posedge clk); model_edge(v); #1;
        end
        chk("md_done.stall_cnt", 32'(stall_cnt), MD_EN ? 32'd4 : 32'd1);

        // Mul/div squashed by redirect does not start.
        v = q; v.id_muldiv = 1; v.redirect = 1;
        step("md_squash", v);
        chk("md_squash.busy", 32'(muldiv_busy), 32'd0);

        // Reset in the middle of a busy mul/div.
        v = q; v.id_muldiv = 1;
        step("md_issue2", v);
        v = r; v.id_hilo = 1;
        drive(v);
        #1;
        chk("rst_mid.pc_en", 32'(pc_en), 32'd0);
        chk("rst_mid.flushes", 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'b111);
        check_comb("rst_mid", v);
        @(posedge clk); model_edge(v); #1;
        chk("rst_mid.busy_q", 32'(muldiv_busy), 32'd0);
        chk("rst_mid.stall_cnt", 32'(stall_cnt), 32'd0);
        v = q; v.id_hilo = 1;
        step("rst_rel", v);
        chk("rst_rel.pc_en", 32'(pc_en), 32'd1);
        chk("rst_rel.state", 32'(fsm_state), 32'(ST_RUN));

        // Randomized run against the reference model.
        for (int i = 0; i < 1500; i++) begin
            v.rst_n        = ($urandom_range(0, 49) != 0);
            v.id_rs        = AW'($urandom_range(0, 3));
            v.id_rt        = AW'($urandom_range(0, 3));
            v.id_use_rs    = 1'($urandom);
            v.id_use_rt    = 1'($urandom);
            v.id_muldiv    = ($urandom_range(0, 4) == 0);
            v.id_hilo      = ($urandom_range(0, 2) == 0);
            v.ex_rs        = AW'($urandom_range(0, 3));
            v.ex_rt        = AW'($urandom_range(0, 3));
            v.ex_memread   = ($urandom_range(0, 2) == 0);
            v.ex_wreg      = AW'($urandom_range(0, 3));
            v.mem_regwrite = 1'($urandom);
            v.wb_regwrite  = 1'($urandom);
            v.mem_wreg     = AW'($urandom_range(0, 3));
            v.wb_wreg      = AW'($urandom_range(0, 3));
            v.redirect     = ($urandom_range(0, 9) == 0);
            step($sformatf("rnd%0d", i), v);
        end

        // Stall counter saturation.
        step("sat_rst", r);
        v = q; v.ex_memread = 1; v.ex_wreg = 4; v.id_rs = 4; v.id_use_rs = 1;
        drive(v);
        repeat (65537) @(posedge clk);
        m_stall = 65535; m_state = ST_STALL;
        #1;
        chk("sat.stall_cnt", 32'(stall_cnt), 32'h0000_FFFF);
        step("sat_hold", v);
        chk("sat_hold.stall_cnt", 32'(stall_cnt), 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
